p_narrow_tx: RTL and testbench



---
 rtl/p_narrow_pkg.sv | 14 +
 rtl/p_narrow_tx_beat_cnt.sv | 28 ++
 rtl/p_narrow_tx.sv | 103 ++++++++++
 tb/tb_p_narrow_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_narrow_pkg.sv
// Shared types and helpers for the p_narrow_tx width-down transmitter.
package p_narrow_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // A single-beat word still needs a 1-bit index so the counter has a port.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/p_narrow_tx_beat_cnt.sv
// Beat index counter: clears on load, counts up to MAX-1 and holds there.
module p_beat_cnt
    import p_narrow_pkg::*;
#(
    parameter int MAX = 4,
    localparam int CW = idx_width(MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    assign at_max = (cnt == CW'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/p_narrow_tx.sv
// Width-down transmitter: one WIDTH*RATIO word in, RATIO WIDTH-bit beats out.
// Define P_NARROW_TX_MSB_FIRST_EN to emit the most significant beat first.
//
// state | meaning
// IDLE  | no word held; in_ready=1, out_valid=0
// SEND  | presenting beat[idx] of the buffered word; out_last on idx==RATIO-1
module p_narrow_tx
    import p_narrow_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*RATIO-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last
);

    localparam int IW = idx_width(RATIO);

    generate
        if (WIDTH < 1 || RATIO < 1) begin : g_bad_param
            $error("p_narrow_tx: WIDTH and RATIO must both be >= 1");
        end
    endgenerate

    state_t                   state, state_nxt;
    logic [WIDTH*RATIO-1:0]   word_q;
    logic [IW-1:0]            idx;
    logic                     at_max;
    logic                     load;
    logic                     beat_done;
    logic [WIDTH-1:0]         beat;

    assign load      = in_valid && in_ready;
    assign out_valid = (state == SEND);
    assign beat_done = out_valid && out_ready;
    assign out_last  = out_valid && at_max;
    assign out_data  = out_valid ? beat : '0;

    p_beat_cnt #(
        .MAX (RATIO)
    ) u_beat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (load),
        .inc    (beat_done),
        .cnt    (idx),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            word_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                word_q <= in_data;
            end
        end
    end

    // in_ready is gated by rst_n so nothing is offered as accepted during reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                in_ready = rst_n && out_ready && at_max;
                if (out_ready && at_max && !in_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        beat = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IW'(k)) begin
`ifdef P_NARROW_TX_MSB_FIRST_EN
                beat = word_q[(RATIO-1-k)*WIDTH +: WIDTH];
`else
                beat = word_q[k*WIDTH +: WIDTH];
`endif
            end
        end
    end

endmodule

// File: tb/tb_p_narrow_tx.sv
// Self-checking bench for p_narrow_tx (WIDTH=4/RATIO=4 and WIDTH=8/RATIO=1 instances)
// against a beat-queue reference model.
module tb_p_narrow_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [15:0] in_data;
    logic [3:0]  out_data;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
    logic [7:0]  in_data1, out_data1;

    int tests = 0;
    int fails = 0;

    logic [3:0] mq[$];
    logic [7:0] mq1[$];

    always #5 clk = ~clk;

    p_narrow_tx #(.WIDTH(4), .RATIO(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    p_narrow_tx #(.WIDTH(8), .RATIO(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_last(out_last1)
    );

    function automatic logic [3:0] beat_of(input logic [15:0] w, input int k);
        logic [15:0] s;
`ifdef P_NARROW_TX_MSB_FIRST_EN
        s = w >> ((3 - k) * 4);
`else
        s = w >> (k * 4);
`endif
        return s[3:0];
    endfunction

    // A new word is taken when nothing is pending or the final pending beat leaves now.
    function automatic logic exp_ready0();
        return (mq.size() == 0) || (out_ready && mq.size() == 1);
    endfunction

    function automatic logic exp_ready1();
        return (mq1.size() == 0) || (out_ready1 && mq1.size() == 1);
    endfunction

    task automatic model_edge0();
        logic acc;
        acc = in_valid && exp_ready0();
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (acc) for (int k = 0; k < 4; k++) mq.push_back(beat_of(in_data, k));
    endtask

    task automatic model_edge1();
        logic acc;
        acc = in_valid1 && exp_ready1();
        if (mq1.size() != 0 && out_ready1) void'(mq1.pop_front());
        if (acc) mq1.push_back(in_data1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: v/l/d/r got %b/%b/%h/%b want 0/0/0/0", out_valid, out_last, out_data, in_ready);
        end
        tests++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs_r1: v/r got %b/%b want 0/0", out_valid1, in_ready1);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: r/v got %b/%b want 1/0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic ev, el, er; logic [3:0] ed;
        logic [3:0] seq [4];
        int seen = 0;
`ifdef P_NARROW_TX_MSB_FIRST_EN
        seq = '{4'hA, 4'h5, 4'hC, 4'h3};
`else
        seq = '{4'h3, 4'hC, 4'h5, 4'hA};
`endif
        for (int c = 0; c < 8; c++) begin
            in_valid = (c == 0); in_data = (c == 0) ? 16'hA5C3 : 16'($urandom); out_ready = 1'b1;
            #1;
            ev = (mq.size() != 0); ed = ev ? mq[0] : 4'h0; el = (mq.size() == 1); er = exp_ready0();
            tests++;
            if (out_valid !== ev || in_ready !== er || (ev && (out_data !== ed || out_last !== el))) begin
                fails++;
                $display("FAIL single c%0d: v/r/d/l got %b/%b/%h/%b want %b/%b/%h/%b", c, out_valid, in_ready, out_data, out_last, ev, er, ed, el);
            end
            if (out_valid === 1'b1 && seen < 4) begin
                tests++;
                if (out_data !== seq[seen] || c != seen + 1) begin
                    fails++;
                    $display("FAIL single_seq beat%0d: got %h at c%0d want %h at c%0d", seen, out_data, c, seq[seen], seen + 1);
                end
                seen++;
            end
            @(posedge clk); model_edge0(); @(negedge clk);
        end
        tests++;
        if (seen != 4) begin
            fails++;
            $display("FAIL single_count: got %0d beats want 4", seen);
        end
    endtask

    task automatic test_backpressure();
        logic ev, el, er; logic [3:0] ed;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0); in_data = (c == 0) ? 16'hA5C3 : 16'($urandom);
            out_ready = !(c >= 2 && c <= 4);
            #1;
            ev = (mq.size() != 0); ed = ev ? mq[0] : 4'h0; el = (mq.size() == 1); er = exp_ready0();
            tests++;
            if (out_valid !== ev || in_ready !== er || (ev && (out_data !== ed || out_last !== el))) begin
                fails++;
                $display("FAIL backpressure c%0d: v/r/d/l got %b/%b/%h/%b want %b/%b/%h/%b", c, out_valid, in_ready, out_data, out_last, ev, er, ed, el);
            end
            @(posedge clk); model_edge0(); @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic ev, el, er, acc; logic [3:0] ed;
        logic [15:0] words [2];
        logic [3:0] seq [8];
        int wi = 0, seen = 0, firstc = -1, lastc = -1;
        words = '{16'h1234, 16'h5678};
`ifdef P_NARROW_TX_MSB_FIRST_EN
        seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`else
        seq = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
`endif
        for (int c = 0; c < 12; c++) begin
            in_valid = (wi < 2); in_data = (wi < 2) ? words[wi] : 16'($urandom); out_ready = 1'b1;
            #1;
            ev = (mq.size() != 0); ed = ev ? mq[0] : 4'h0; el = (mq.size() == 1); er = exp_ready0();
            tests++;
            if (out_valid !== ev || in_ready !== er || (ev && (out_data !== ed || out_last !== el))) begin
                fails++;
                $display("FAIL back_to_back c%0d: v/r/d/l got %b/%b/%h/%b want %b/%b/%h/%b", c, out_valid, in_ready, out_data, out_last, ev, er, ed, el);
            end
            if (out_valid === 1'b1 && seen < 8) begin
                tests++;
                if (out_data !== seq[seen]) begin
                    fails++;
                    $display("FAIL b2b_seq beat%0d: got %h want %h", seen, out_data, seq[seen]);
                end
                if (firstc < 0) firstc = c;
                lastc = c;
                seen++;
            end
            acc = in_valid && er;
            @(posedge clk); model_edge0(); if (acc) wi++; @(negedge clk);
        end
        tests++;
        if (seen != 8 || lastc - firstc != 7) begin
            fails++;
            $display("FAIL b2b_gapless: got %0d beats over %0d cycles want 8 over 8", seen, lastc - firstc + 1);
        end
    endtask

    task automatic test_reset_mid_word();
        logic ev, el, er; logic [3:0] ed;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0); in_data = 16'hA5C3; out_ready = 1'b1;
            if (c == 3) begin
                #1;
                tests++;
                if (out_valid !== 1'b1 || out_data !== mq[0]) begin
                    fails++;
                    $display("FAIL midreset_pre: v/d got %b/%h want 1/%h", out_valid, out_data, mq[0]);
                end
                #1 rst_n = 1'b0; #1;
                tests++;
                if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL midreset_async: v/l/r got %b/%b/%b want 0/0/0", out_valid, out_last, in_ready);
                end
                mq.delete();
                @(posedge clk); @(negedge clk);
            end else begin
                @(posedge clk); model_edge0(); @(negedge clk);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            ev = (mq.size() != 0); ed = ev ? mq[0] : 4'h0; el = (mq.size() == 1); er = exp_ready0();
            tests++;
            if (out_valid !== ev || in_ready !== er || (ev && (out_data !== ed || out_last !== el))) begin
                fails++;
                $display("FAIL midreset_after c%0d: v/r/d/l got %b/%b/%h/%b want %b/%b/%h/%b", c, out_valid, in_ready, out_data, out_last, ev, er, ed, el);
            end
            @(posedge clk); model_edge0(); @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic ev, el, er; logic [3:0] ed;
        for (int c = 0; c < 400; c++) begin
            if (c < 390) begin
                in_valid = 1'($urandom_range(0, 1)); out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            in_data = 16'($urandom);
            #1;
            ev = (mq.size() != 0); ed = ev ? mq[0] : 4'h0; el = (mq.size() == 1); er = exp_ready0();
            tests++;
            if (out_valid !== ev || in_ready !== er || (ev && (out_data !== ed || out_last !== el))) begin
                fails++;
                $display("FAIL random c%0d: v/r/d/l got %b/%b/%h/%b want %b/%b/%h/%b", c, out_valid, in_ready, out_data, out_last, ev, er, ed, el);
            end
            @(posedge clk); model_edge0(); @(negedge clk);
        end
    endtask

    task automatic test_ratio1();
        logic ev, er; logic [7:0] ed;
        in_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c == 0) begin
                in_valid1 = 1'b1; in_data1 = 8'h5A; out_ready1 = 1'b1;
            end else if (c < 10) begin
                in_valid1 = 1'b1; in_data1 = 8'($urandom); out_ready1 = 1'b1;
            end else begin
                in_valid1 = 1'($urandom_range(0, 1)); in_data1 = 8'($urandom);
                out_ready1 = ($urandom_range(0, 2) != 0);
            end
            #1;
            ev = (mq1.size() != 0); ed = ev ? mq1[0] : 8'h00; er = exp_ready1();
            tests++;
            if (out_valid1 !== ev || in_ready1 !== er || (ev && (out_data1 !== ed || out_last1 !== 1'b1))) begin
                fails++;
                $display("FAIL ratio1 c%0d: v/r/d/l got %b/%b/%h/%b want %b/%b/%h/%b", c, out_valid1, in_ready1, out_data1, out_last1, ev, er, ed, ev);
            end
            if (c == 1) begin
                tests++;
                if (out_valid1 !== 1'b1 || out_data1 !== 8'h5A || out_last1 !== 1'b1) begin
                    fails++;
                    $display("FAIL ratio1_first: v/d/l got %b/%h/%b want 1/5a/1", out_valid1, out_data1, out_last1);
                end
            end
            @(posedge clk); model_edge1(); @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        test_ratio1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
